// File: rtl/ysyx_24090018_inst_fetch.sv
// Instruction fetch stage: one outstanding read over an AR/R channel, then the fetched
// instruction is handed to the datapath over a valid/ready handshake.
module ysyx_24090018_inst_fetch #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              fetch_err_o,
    output logic [31:0]       fetch_cnt_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INST);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_inst;
    logic                r_err;
    logic [31:0]         r_cnt;

    logic                w_ar_fire;
    logic                w_r_fire;
    logic                w_inst_fire;

    always_comb begin
        w_ar_fire   = (r_state == S_ADDR) && arready_i;
        w_r_fire    = (r_state == S_DATA) && rvalid_i;
        w_inst_fire = (r_state == S_HOLD) && inst_ready_i;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = S_ADDR;
            S_ADDR:  if (w_ar_fire)   w_next = S_DATA;
            S_DATA:  if (w_r_fire)    w_next = S_HOLD;
            S_HOLD:  if (w_inst_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_inst  <= NOP_W;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // The IDLE bubble gives the PC register a cycle to settle before it is captured.
            if (r_state == S_IDLE) begin
                r_addr <= pc_i;
            end
            if (w_r_fire) begin
                r_inst <= rdata_i;
                r_err  <= (rresp_i != 2'b00);
            end
            if (w_inst_fire) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        arvalid_o    = (r_state == S_ADDR);
        araddr_o     = r_addr;
        rready_o     = (r_state == S_DATA);
        inst_valid_o = (r_state == S_HOLD);
        inst_o       = (r_state == S_HOLD) ? r_inst : NOP_W;
        fetch_err_o  = (r_state == S_HOLD) && r_err;
        fetch_cnt_o  = r_cnt;
    end

endmodule

// File: tb/tb_ysyx_24090018_inst_fetch.sv
// Bench for the fetch stage: transaction-level reference model, directed scenarios and
// randomized channel/handshake traffic with occasional resets.
module tb_ysyx_24090018_inst_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        fetch_err_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;

    ysyx_24090018_inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .fetch_err_o  (fetch_err_o),
        .fetch_cnt_o  (fetch_cnt_o),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which transaction step is pending, plus captured data.
    bit          m_bubble, m_addr_out, m_data_out, m_inst_out;
    logic [31:0] m_addr, m_inst, m_cnt;
    bit          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_bubble = 1; m_addr_out = 0; m_data_out = 0; m_inst_out = 0;
            m_addr = 0; m_inst = NOP; m_err = 0; m_cnt = 0;
        end else if (m_bubble) begin
            m_addr = pc_i; m_bubble = 0; m_addr_out = 1;
        end else if (m_addr_out && arready_i) begin
            m_addr_out = 0; m_data_out = 1;
        end else if (m_data_out && rvalid_i) begin
            m_inst = rdata_i; m_err = (rresp_i != 2'b00);
            m_data_out = 0; m_inst_out = 1;
        end else if (m_inst_out && inst_ready_i) begin
            m_cnt = m_cnt + 1; m_inst_out = 0; m_bubble = 1;
        end
    endtask

    task automatic compare_all();
        check("arvalid", arvalid_o, m_addr_out);
        check("araddr", araddr_o, m_addr);
        check("rready", rready_o, m_data_out);
        check("inst_valid", inst_valid_o, m_inst_out);
        check("inst", inst_o, m_inst_out ? m_inst : NOP);
        check("fetch_err", fetch_err_o, m_inst_out && m_err);
        check("fetch_cnt", fetch_cnt_o, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        pc_i         = $urandom;
        arready_i    = $urandom_range(0, 1);
        rvalid_i     = $urandom_range(0, 1);
        rdata_i      = $urandom;
        rresp_i      = 2'($urandom_range(0, 3));
        inst_ready_i = $urandom_range(0, 1);
    endtask

    task automatic idle_inputs();
        arready_i = 0; rvalid_i = 0; inst_ready_i = 0; rresp_i = 0; rdata_i = 0;
    endtask

    initial begin
        int          seen;
        logic [31:0] held_inst;

        // T1: reset with random inputs on the channels
        rst = 0;
        rand_inputs();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            check("rst_arvalid", arvalid_o, 1'b0);
            check("rst_inst", inst_o, NOP);
            check("rst_cnt", fetch_cnt_o, 32'd0);
            check("rst_araddr", araddr_o, 32'd0);
        end

        // T2: zero-wait fetch
        idle_inputs();
        rst = 1; pc_i = 32'h80000000; arready_i = 1; rvalid_i = 1;
        rdata_i = 32'h00500093;
        step();
        check("t2_arvalid_c1", arvalid_o, 1'b1);
        check("t2_araddr_c1", araddr_o, 32'h80000000);
        step();
        check("t2_rready_c2", rready_o, 1'b1);
        step();
        check("t2_valid_c3", inst_valid_o, 1'b1);
        check("t2_inst_c3", inst_o, 32'h00500093);
        inst_ready_i = 1;
        step();
        check("t2_cnt", fetch_cnt_o, 32'd1);
        check("t2_valid_off", inst_valid_o, 1'b0);

        // T3: arready low 3 cycles, rvalid low 2 cycles; now in c0 (IDLE)
        idle_inputs();
        pc_i = 32'h80000004; rdata_i = 32'h00A00113;
        seen = -1;
        for (int k = 0; k < 20; k++) begin
            if (inst_valid_o && seen < 0) seen = k;
            if (seen >= 0) break;
            arready_i = (k >= 4);
            rvalid_i  = (k >= 7);
            pc_i      = (k == 0) ? 32'h80000004 : $urandom;
            step();
            if (arvalid_o) check("t3_araddr", araddr_o, 32'h80000004);
        end
        check("t3_latency", 64'(seen), 64'd8);
        check("t3_inst", inst_o, 32'h00A00113);

        // T4: backpressure in HOLD for 5 cycles
        held_inst = inst_o;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            pc_i = $urandom;
            arready_i = 1; rvalid_i = 1; rdata_i = $urandom;
            step();
            check("t4_held", inst_o, held_inst);
            check("t4_no_ar", arvalid_o, 1'b0);
        end
        inst_ready_i = 1; pc_i = 32'h11112222;
        step();
        check("t4_cnt", fetch_cnt_o, 32'd2);
        idle_inputs(); pc_i = 32'h80000010;
        step();
        check("t4_new_addr", araddr_o, 32'h80000010);

        // T5: error response
        arready_i = 1;
        step();
        rvalid_i = 1; rresp_i = 2'b10; rdata_i = 32'hDEADBEEF; arready_i = 0;
        step();
        check("t5_valid", inst_valid_o, 1'b1);
        check("t5_err", fetch_err_o, 1'b1);
        check("t5_inst", inst_o, 32'hDEADBEEF);
        rvalid_i = 0; inst_ready_i = 1;
        step();
        check("t5_cnt", fetch_cnt_o, 32'd3);

        // T6: reset in DATA while rvalid is high
        idle_inputs(); pc_i = 32'h80000020;
        step();
        arready_i = 1;
        step();
        check("t6_in_data", rready_o, 1'b1);
        rst = 0; rvalid_i = 1; rdata_i = 32'hCAFEF00D;
        step();
        check("t6_cnt", fetch_cnt_o, 32'd0);
        check("t6_valid", inst_valid_o, 1'b0);
        rst = 1; rvalid_i = 0; arready_i = 0; pc_i = 32'h80000040;
        step();
        check("t6_addr", araddr_o, 32'h80000040);

        // Randomized traffic with sparse resets
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
